// File: rtl/i2c_write_burst.sv
// i2c_write_burst: I2C master write burst (START, addr+W, up to MAX_BYTES data bytes, STOP), TICK-paced.
// Define I2C_WRITE_BURST_ABORT_ON_NACK_EN to stop the burst at the first NACKed slot.
module i2c_write_burst #(
  parameter int MAX_BYTES = 4,
  parameter int NB_W      = 5
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  input  logic                   TICK,
  input  logic                   GO,
  input  logic [6:0]             SLAVE_ADDR,
  input  logic [8*MAX_BYTES-1:0] WDATA,
  input  logic [NB_W-1:0]        NBYTES,
  input  logic                   SDAI,
  output logic                   SDAO,
  output logic                   SCLO,
  output logic                   BUSY,
  output logic                   DONE,
  output logic                   NACK,
  output logic [NB_W-1:0]        NACK_IDX
);
  typedef enum logic [3:0] {IDLE, START1, START2, BIT_D, BIT_H, BIT_L, STOP1, STOP2, STOP3, FIN} state_t;
  state_t r_state, w_next;
  logic r_go, r_nack;
  logic [3:0] r_bit;
  logic [NB_W-1:0] r_byte, r_n, r_nack_idx;
  logic [7:0] r_cur;
  logic [8*MAX_BYTES-1:0] r_data;
  logic w_start, w_ack, w_bit, w_last;
  logic [NB_W-1:0] w_nclamp;
  assign w_start  = (r_state == IDLE) && GO && !r_go;
  assign w_ack    = r_bit == 4'd8;
  assign w_bit    = w_ack ? 1'b1 : r_cur[~r_bit[2:0]];
  assign w_nclamp = (NBYTES > NB_W'(MAX_BYTES)) ? NB_W'(MAX_BYTES) : NBYTES;
`ifdef I2C_WRITE_BURST_ABORT_ON_NACK_EN
  assign w_last   = (r_byte == r_n) || r_nack;
`else
  assign w_last   = r_byte == r_n;
`endif
  assign BUSY     = r_state != IDLE;
  assign DONE     = r_state == FIN;
  assign NACK     = r_nack;
  assign NACK_IDX = r_nack_idx;
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    SDAO = 1'b1;
    SCLO = 1'b1;
    case (r_state)
      IDLE:   w_next = w_start ? START1 : IDLE;
      START1: begin SDAO = 1'b0; w_next = TICK ? START2 : START1; end
      START2: begin SDAO = 1'b0; SCLO = 1'b0; w_next = TICK ? BIT_D : START2; end
      BIT_D:  begin SDAO = w_bit; SCLO = 1'b0; w_next = TICK ? BIT_H : BIT_D; end
      BIT_H:  begin SDAO = w_bit; w_next = TICK ? BIT_L : BIT_H; end
      BIT_L:  begin SDAO = w_bit; SCLO = 1'b0; w_next = !TICK ? BIT_L : (w_ack && w_last) ? STOP1 : BIT_D; end
      STOP1:  begin SDAO = 1'b0; SCLO = 1'b0; w_next = TICK ? STOP2 : STOP1; end
      STOP2:  begin SDAO = 1'b0; w_next = TICK ? STOP3 : STOP2; end
      STOP3:  w_next = TICK ? FIN : STOP3;
      FIN:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  // GO history resets high so a GO held through reset is not seen as an edge
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) begin
      r_go <= 1'b1;
      r_nack <= 1'b0;
      r_nack_idx <= '0;
      r_bit <= '0;
      r_byte <= '0;
      r_n <= '0;
      r_cur <= '0;
      r_data <= '0;
    end else begin
      r_go <= GO;
      if (w_start) begin
        r_nack <= 1'b0;
        r_nack_idx <= '0;
        r_bit <= '0;
        r_byte <= '0;
        r_n <= w_nclamp;
        r_cur <= {SLAVE_ADDR, 1'b0};
        r_data <= WDATA;
      end else if (TICK && r_state == BIT_H && w_ack && SDAI) begin
        r_nack <= 1'b1;
        if (!r_nack) r_nack_idx <= r_byte;
      end else if (TICK && r_state == BIT_L) begin
        r_bit <= w_ack ? 4'd0 : r_bit + 4'd1;
        if (w_ack) begin
          r_byte <= r_byte + NB_W'(1);
          r_cur <= r_data[8*MAX_BYTES-1 -: 8];
          r_data <= r_data << 8;
        end
      end
    end
endmodule
